booth_mult_seq: RTL
===================

// Module: booth_mult_seq
// PURPOSE
//  Sequential radix-2 Booth multiplier; one Booth step per clock.
//  Upstream: two operands from keypad entry control (operand registers + start strobe).
//  Downstream: product drives binary-to-BCD conversion and the 7-segment display path.
//  Shift/add datapath with start/busy/valid handshake; no combinational multiply.
// PARAMETERS
//  WIDTH  8  operand width in bits; product is 2*WIDTH bits
// PORTS
//  clk           in   1        system clock, all state on rising edge
//  rst           in   1        asynchronous, active-low reset (0 = reset)
//  start         in   1        one-cycle request; sampled only when busy=0
//  clear         in   1        synchronous abort; returns to IDLE
//  multiplicand  in   WIDTH    operand M, captured on accepted start
//  multiplier    in   WIDTH    operand Q, captured on accepted start
//  busy          out  1        high from accept cycle+1 until DONE exits
//  valid         out  1        one-cycle pulse, product just updated
//  product       out  2*WIDTH  last completed result, held until next completion
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, busy=0, valid=0, product=0, all internal regs=0.
//  States: IDLE -> CALC -> DONE -> IDLE.
//  IDLE: start=1 and clear=0 -> capture M and Q, A=0, Q_-1=0, cnt=N, go CALC.
//  CALC: per cycle, examine {Q[0],Q_-1}:
//    01 -> A=A+M, 10 -> A=A-M, 00/11 -> no-op.
//    Then arithmetic shift right {A,Q,Q_-1} by 1 and decrement cnt.
//    On last step (cnt==1), go DONE.
//  DONE: product <= low 2*WIDTH bits of {A,Q}; valid=1 for this cycle; go IDLE.
//  Width rules:
//    A, M are sign-extended to WIDTH+1 bits internally.
//    This keeps -M exact for M = -2^(WIDTH-1).
//    Sums wrap modulo 2^(WIDTH+1); no other overflow is possible.
//  Latency: start accepted at edge k -> valid=1 during cycle k+N+1 -> busy=0 at k+N+2.
//  start while busy=1: ignored; no queueing; operands not re-sampled.
//  start and valid in the same cycle: ignored; accepted from the next IDLE cycle.
//  clear=1 in any state:
//    Next state is IDLE; busy=0; valid not asserted; product unchanged.
//    clear has priority over start.
//  Reset mid-operation: immediate abort; product=0.
//  Operands may change freely after the accept cycle without effect.
// CONFIGURATION
//  BOOTH_SIGNED_EN defined:
//    Operands and product are two's complement.
//    N=WIDTH steps; latency WIDTH+1.
//  BOOTH_SIGNED_EN undefined (default):
//    Operands are unsigned.
//    M and Q are zero-extended to WIDTH+1 bits.
//    N=WIDTH+1 steps; latency WIDTH+2.
//    product is the unsigned 2*WIDTH-bit result.
// TESTING (WIDTH=8)
//  1. Signed: M=3, Q=-4 (0xFC)
//     -> valid at accept+9; product=0xFFF4; busy low next cycle.
//  2. Signed corner: M=0x80, Q=0x80 -> product=0x4000.
//     Also M=0x80, Q=0x7F -> product=0xC080.
//  3. Unsigned: M=0xFF, Q=0xFF -> valid at accept+10; product=0xFE01.
//     Also M=0, Q=0xA5 -> product=0x0000.
//  4. start pulsed at accept+3 with new operands -> ignored.
//     Result is that of the first operands; exactly one valid pulse.
//  5. clear=1 at accept+4 (prior product=0x0123) -> IDLE next cycle.
//     No valid pulse; product stays 0x0123; a new start then completes normally.
//  6. rst=0 asserted mid-CALC, no clock edge -> busy=0, valid=0, product=0 immediately.
//     After release, a start runs a full-latency multiply.

Source files
------------

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one recoding step per clock, start/busy/valid handshake.
// Define BOOTH_SIGNED_EN for two's-complement operands; default build is unsigned (one extra step).
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clear,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] product
);

  // A and M carry one guard bit so that -M stays exact for the most negative M.
  localparam int AW = WIDTH + 1;
`ifdef BOOTH_SIGNED_EN
  localparam int QW    = WIDTH;
  localparam int NSTEP = WIDTH;
`else
  // Unsigned Q gets a zero sign bit, which costs one more Booth step.
  localparam int QW    = WIDTH + 1;
  localparam int NSTEP = WIDTH + 1;
`endif
  localparam int CW = $clog2(NSTEP + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic                 w_last;

  logic [AW-1:0]        r_m;
  logic [AW-1:0]        r_a;
  logic [QW-1:0]        r_q;
  logic                 r_qm1;
  logic [CW-1:0]        r_cnt;
  logic                 r_valid;
  logic [2*WIDTH-1:0]   r_product;

  logic [AW-1:0]        w_m_ext;
  logic [QW-1:0]        w_q_ext;
  logic [AW-1:0]        w_sum;
  logic [AW-1:0]        w_a_nxt;
  logic [QW-1:0]        w_q_nxt;
  logic [2*WIDTH-1:0]   w_prod_nxt;

`ifdef BOOTH_SIGNED_EN
  assign w_m_ext = {multiplicand[WIDTH-1], multiplicand};
  assign w_q_ext = multiplier;
`else
  assign w_m_ext = {1'b0, multiplicand};
  assign w_q_ext = {1'b0, multiplier};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !clear) begin
          w_state_nxt = S_CALC;
          w_accept    = 1'b1;
        end
      end
      S_CALC: begin
        if (clear) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CW'(1)) begin
          w_state_nxt = S_DONE;
          w_last      = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_a + r_m;
      2'b10:   w_sum = r_a - r_m;
      default: w_sum = r_a;
    endcase
  end

  // Arithmetic shift right of {A,Q,Q_-1}
  assign w_a_nxt    = {w_sum[AW-1], w_sum[AW-1:1]};
  assign w_q_nxt    = {w_sum[0], r_q[QW-1:1]};
  assign w_prod_nxt = (2*WIDTH)'({w_a_nxt, w_q_nxt});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m       <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_product <= '0;
    end else begin
      r_valid <= w_last;
      if (w_accept) begin
        r_m   <= w_m_ext;
        r_a   <= '0;
        r_q   <= w_q_ext;
        r_qm1 <= 1'b0;
        r_cnt <= CW'(NSTEP);
      end else if (r_state == S_CALC && !clear) begin
        r_a   <= w_a_nxt;
        r_q   <= w_q_nxt;
        r_qm1 <= r_q[0];
        r_cnt <= r_cnt - CW'(1);
      end
      // Product is loaded on the final step so it is already stable while valid is high.
      if (w_last) begin
        r_product <= w_prod_nxt;
      end
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign valid   = r_valid;
  assign product = r_product;

endmodule
